// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, transfer sizes and legality check for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;
  // Bound check runs in 65 bits so addresses near 2^64 cannot wrap into range
  function automatic logic size_legal(input logic [3:0] size, input logic [63:0] addr, input logic [64:0] depth);
    return (size == SZ_B || size == SZ_H || size == SZ_W || size == SZ_D) &&
           ((addr[3:0] & (size - 4'd1)) == 4'd0) &&
           ({1'b0, addr} + {61'd0, size} <= depth);
  endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage load/store request and response channels
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  modport master (output req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: byte storage with an 8-lane big-endian write/read window at a base address
module dmem_byte_array #(
    parameter int DEPTH_BYTES = 1024,
    localparam int AW = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic [7:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);
    logic [7:0] mem [DEPTH_BYTES];
    // Lane i maps to byte addr+i; lane 0 is the most significant byte of the window
    always_ff @(posedge clk)
        for (int i = 0; i < 8; i++)
            if (we[i]) mem[addr + AW'(i)] <= wdata[63-8*i -: 8];
    for (genvar g = 0; g < 8; g++) begin : g_rd
        assign rdata[63-8*g -: 8] = mem[addr + AW'(g)];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle big-endian data-memory target with configurable latency
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  s,
    output logic   busy
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(LATENCY) + 1;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          write_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [3:0]    size_q;
    logic          legal;
    logic [6:0]    sh;
    logic [7:0]    we;
    logic [63:0]   win;
    // Transfers are left-justified into the 8-byte window so lane 0 always holds mem[addr]
    always_comb begin
        legal = size_legal(size_q, addr_q, 65'(DEPTH_BYTES));
        sh = {4'd8 - size_q, 3'd0};
        we = '0;
        for (int i = 0; i < 8; i++) we[i] = state == ACCESS && write_q && legal && 4'(i) < size_q;
    end
    dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_mem (
        .clk  (clk),
        .we   (we),
        .addr (addr_q[AW-1:0]),
        .wdata(wdata_q << sh),
        .rdata(win)
    );
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            s.req_ready <= 1'b1;
            s.rsp_valid <= 1'b0;
            s.rsp_rdata <= '0;
            s.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s.req_valid) begin
                    write_q     <= s.req_write;
                    addr_q      <= s.req_addr;
                    wdata_q     <= s.req_wdata;
                    size_q      <= s.req_size;
                    cnt         <= CW'(LATENCY - 1);
                    s.req_ready <= 1'b0;
                    state       <= LATENCY == 1 ? ACCESS : WAIT;
                end
                WAIT: begin
                    cnt   <= cnt - 1'b1;
                    state <= cnt == CW'(1) ? ACCESS : WAIT;
                end
                ACCESS: begin
                    s.rsp_valid <= 1'b1;
                    s.rsp_err   <= !legal;
                    s.rsp_rdata <= legal && !write_q ? win >> sh : '0;
                    state       <= RESP;
                end
                RESP: if (s.rsp_ready) begin
                    s.rsp_valid <= 1'b0;
                    s.req_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with a byte-array reference model checked every cycle
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;
    logic clk, rst, a_busy, b_busy;
    int   checks = 0, errors = 0, cyc = 0;
    dmem_if a_if ();
    dmem_if b_if ();
    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut_a (.clk(clk), .rst(rst), .s(a_if), .busy(a_busy));
    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1))   dut_b (.clk(clk), .rst(rst), .s(b_if), .busy(b_busy));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    logic [7:0] ref_mem [DEPTH];
    function automatic logic mlegal(input logic [63:0] a, input logic [3:0] s);
        if (!(s == 1 || s == 2 || s == 4 || s == 8)) return 1'b0;
        return (a % 64'(s) == 0) && ({1'b0, a} + 65'(s) <= 65'(DEPTH));
    endfunction
    function automatic logic [63:0] mload(input logic [63:0] a, input logic [3:0] s);
        logic [63:0] r = '0;
        for (int i = 0; i < int'(s); i++) r = {r[55:0], ref_mem[int'(a[31:0]) + i]};
        return r;
    endfunction
    function automatic void mstore(input logic [63:0] a, input logic [63:0] d, input logic [3:0] s);
        for (int i = 0; i < int'(s); i++) ref_mem[int'(a[31:0]) + i] = d[8*(int'(s)-1-i) +: 8];
    endfunction

    typedef struct {
        logic        w;
        logic [63:0] a, d;
        logic [3:0]  s;
        int          acc;
        logic        seen;
        logic [63:0] ed;
        logic        ee;
    } txn_t;
    txn_t q[$];
    txn_t t, nt;

    // Expectations are resolved when the response first appears, i.e. when the store lands
    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (q.size() == 0) begin
                chk("idle_rsp_valid", a_if.rsp_valid, 0);
                chk("idle_req_ready", a_if.req_ready, 1);
                chk("idle_busy", a_busy, 0);
            end else begin
                t = q[0];
                if (!t.seen && (a_if.rsp_valid || cyc >= t.acc + LAT)) begin
                    chk("rsp_latency", 64'(cyc), 64'(t.acc + LAT));
                    t.ee = !mlegal(t.a, t.s);
                    t.ed = (!t.w && !t.ee) ? mload(t.a, t.s) : 64'd0;
                    if (t.w && !t.ee) mstore(t.a, t.d, t.s);
                    t.seen = 1'b1;
                    q[0] = t;
                end
                chk("op_busy", a_busy, 1);
                chk("op_req_ready", a_if.req_ready, 0);
                chk("rsp_valid", a_if.rsp_valid, t.seen);
                if (t.seen) begin
                    chk("rsp_rdata", a_if.rsp_rdata, t.ed);
                    chk("rsp_err", a_if.rsp_err, t.ee);
                end
            end
            if (a_if.req_valid && a_if.req_ready) begin
                nt = '{w: a_if.req_write, a: a_if.req_addr, d: a_if.req_wdata, s: a_if.req_size,
                       acc: cyc + 1, seen: 1'b0, ed: '0, ee: 1'b0};
                q.push_back(nt);
            end
        end
    end
    always @(posedge clk)
        if (!rst && q.size() != 0 && a_if.rsp_valid && a_if.rsp_ready) void'(q.pop_front());

    logic [63:0] b_exp [4] = '{64'h0, 64'h1122334455667788, 64'h55667788, 64'h22};
    int b_nrsp = 0, b_nacc = 0, b_last = 0;
    always @(negedge clk)
        if (!rst) begin
            if (b_if.rsp_valid) begin
                chk("b_latency", 64'(cyc), 64'(b_last + 1));
                if (b_nrsp < 4) chk("b_rdata", b_if.rsp_rdata, b_exp[b_nrsp]);
                chk("b_err", b_if.rsp_err, 0);
                b_nrsp++;
            end
            if (b_if.req_valid && b_if.req_ready) begin
                if (b_nacc > 0) chk("b_accept_spacing", 64'(cyc + 1 - b_last), 64'd3);
                b_last = cyc + 1;
                b_nacc++;
            end
        end

    task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [3:0] s,
                        input int bp, output logic [63:0] rd, output logic e);
        int n = 0;
        a_if.req_write = w; a_if.req_addr = a; a_if.req_wdata = d; a_if.req_size = s; a_if.req_valid = 1'b1;
        @(negedge clk);
        while (!a_if.req_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_in_time", n < 20, 1);
        @(posedge clk);
        #1;
        a_if.req_valid = 1'b0; a_if.req_write = ~w; a_if.req_addr = ~a; a_if.req_wdata = ~d; a_if.req_size = 4'd8;
        if (bp == 0) a_if.rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_if.rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("rsp_in_time", n < 20, 1);
        rd = a_if.rsp_rdata;
        e  = a_if.rsp_err;
        repeat (bp) begin @(negedge clk); chk("bp_req_ready", a_if.req_ready, 0); end
        #1 a_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1 a_if.rsp_ready = 1'b0;
        chk("ready_after_rsp", a_if.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [63:0] rd;
    logic e;
    logic [63:0] b_addr [4] = '{64'h8, 64'h8, 64'hC, 64'h9};
    logic [3:0]  b_size [4] = '{4'd8, 4'd8, 4'd4, 4'd1};
    logic        b_wr   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    initial begin
        rst = 1'b1;
        a_if.req_valid = 0; a_if.req_write = 0; a_if.req_addr = 0; a_if.req_wdata = 0; a_if.req_size = 0; a_if.rsp_ready = 0;
        b_if.req_valid = 0; b_if.req_write = 0; b_if.req_addr = 0; b_if.req_wdata = 0; b_if.req_size = 0; b_if.rsp_ready = 1;
        @(posedge clk);
        #1;
        chk("rst_req_ready", a_if.req_ready, 1);
        chk("rst_rsp_valid", a_if.rsp_valid, 0);
        chk("rst_rsp_rdata", a_if.rsp_rdata, 0);
        chk("rst_rsp_err", a_if.rsp_err, 0);
        chk("rst_busy", a_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        xact(1, 64'h10, 64'h0123456789ABCDEF, 8, 0, rd, e);
        chk("st8_rdata", rd, 0); chk("st8_err", e, 0);
        xact(0, 64'h10, 0, 8, 0, rd, e);
        chk("ld8_0x10", rd, 64'h0123456789ABCDEF); chk("ld8_err", e, 0);
        xact(0, 64'h10, 0, 1, 0, rd, e);
        chk("ld1_0x10", rd, 64'h01);
        xact(0, 64'h16, 0, 2, 0, rd, e);
        chk("ld2_0x16", rd, 64'hCDEF);
        xact(1, 64'h20, 64'h0, 8, 0, rd, e);
        xact(1, 64'h20, 64'hFFFFFFFF_DEADBEEF, 4, 0, rd, e);
        chk("st4_err", e, 0);
        xact(0, 64'h20, 0, 8, 0, rd, e);
        chk("ld8_0x20", rd, 64'hDEADBEEF_00000000);

        xact(0, 64'h14, 0, 8, 0, rd, e);
        chk("misaligned_err", e, 1); chk("misaligned_rdata", rd, 0);
        xact(1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 3, 0, rd, e);
        chk("size3_err", e, 1);
        xact(0, DEPTH - 4, 0, 8, 0, rd, e);
        chk("past_end_err", e, 1); chk("past_end_rdata", rd, 0);
        xact(0, DEPTH, 0, 4, 0, rd, e);
        chk("at_end_err", e, 1);
        xact(0, 64'hFFFFFFFF_FFFFFFF8, 0, 8, 0, rd, e);
        chk("wrap_err", e, 1);
        xact(0, DEPTH - 8, 0, 4, 0, rd, e);
        xact(0, 64'h10, 0, 8, 0, rd, e);
        chk("reload_0x10", rd, 64'h0123456789ABCDEF);

        xact(0, 64'h20, 0, 8, 5, rd, e);
        chk("bp_ld8_0x20", rd, 64'hDEADBEEF_00000000);

        xact(1, 64'h40, 64'h5555555555555555, 8, 0, rd, e);
        xact(0, 64'h40, 0, 8, 0, rd, e);
        chk("ld8_0x40", rd, 64'h5555555555555555);
        a_if.req_write = 1; a_if.req_addr = 64'h40; a_if.req_wdata = 64'hAAAAAAAAAAAAAAAA; a_if.req_size = 8; a_if.req_valid = 1;
        @(negedge clk);
        @(posedge clk);
        #1 a_if.req_valid = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_req_ready", a_if.req_ready, 1);
        chk("midrst_rsp_valid", a_if.rsp_valid, 0);
        chk("midrst_rsp_rdata", a_if.rsp_rdata, 0);
        chk("midrst_rsp_err", a_if.rsp_err, 0);
        chk("midrst_busy", a_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        xact(0, 64'h40, 0, 8, 0, rd, e);
        chk("ld8_0x40_after_rst", rd, 64'h5555555555555555);

        for (int k = 0; k < 4; k++) begin
            int n = 0;
            b_if.req_write = b_wr[k]; b_if.req_addr = b_addr[k]; b_if.req_size = b_size[k];
            b_if.req_wdata = 64'h1122334455667788; b_if.req_valid = 1'b1;
            @(negedge clk);
            while (!b_if.req_ready && n < 10) begin @(negedge clk); n++; end
            chk("b_accept_in_time", n < 10, 1);
            @(posedge clk);
            #1;
        end
        b_if.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("b_responses", 64'(b_nrsp), 64'd4);
        chk("b_accepts", 64'(b_nacc), 64'd4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
